// File: rtl/alu_ctrl_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer_pkg
// Shared definitions for the ALU control-step sequencer:
//   - opcode constants for register-register ALU instructions
//   - control-step state encoding (IDLE, T0..T5, plus T6 when multiply/divide
//     support is built in)
//   - IR field bit positions
//   - opcode class and the control-word bundle driven onto the datapath
// Configuration macro: ALU_MULDIV_EN (adds MUL/DIV and the T6 step).
// -----------------------------------------------------------------------------
package alu_ctrl_sequencer_pkg;

  // IR field positions: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int IR_LO = RC_LO;  // lowest IR bit the sequencer looks at

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
`ifdef ALU_MULDIV_EN
    , S_T6 = 3'd7
`endif
  } state_t;

  typedef enum logic [1:0] {
    CLS_BINARY  = 2'd0,
    CLS_UNARY   = 2'd1,
    CLS_MULDIV  = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

  // One control step's worth of datapath strobes and selects.
  typedef struct packed {
    logic       pc_out;
    logic       mar_in;
    logic       inc_pc;
    logic       z_in;
    logic       pc_in;
    logic       read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       y_in;
    logic       zlow_out;
    logic       zhigh_out;
    logic       lo_in;
    logic       hi_in;
    logic       r_out_en;
    logic       r_in_en;
    logic       done;
    logic       illegal;
    logic [3:0] r_sel;
    logic [4:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_sequencer_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer_decode
// Combinational opcode classifier: binary, unary, multiply/divide or illegal.
// Ports:
//   op       in  5  opcode field of the IR
//   op_class out    class of the opcode
// Configuration macro: ALU_MULDIV_EN (MUL/DIV classify as CLS_MULDIV when
// defined, otherwise they are illegal).
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer_decode
  import alu_ctrl_sequencer_pkg::*;
(
  input  logic [4:0] op,
  output op_class_t  op_class
);

  always_comb begin
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class = CLS_BINARY;
      OP_NEG, OP_NOT:                   op_class = CLS_UNARY;
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_DIV:                   op_class = CLS_MULDIV;
`endif
      default:                          op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer
// Control-step generator for register-register ALU instructions. Runs fetch
// (T0-T2) and execute (T3-T5, or T3-T6 for MUL/DIV) and drives the datapath
// strobes as a decode of the current step.
// Ports:
//   clk, clr          clock; synchronous active-high reset
//   run               level; start / continue instruction sequencing
//   mem_rdy           memory data valid during T1
//   ir[31:0]          IR contents from the datapath (sampled in T3)
//   pc_out..hi_in     one-bit datapath bus-drive / load strobes
//   r_out_en/r_in_en  drive / load the register selected by r_sel[3:0]
//   alu_op[4:0]       ALU opcode, non-zero only on the step that loads Z
//   busy              state is not IDLE
//   done              final execute step
//   illegal           unsupported opcode seen in T3
//   fault             sticky T1 memory timeout, cleared only by clr
// Parameters: MEM_TIMEOUT (T1 wait limit, 1..255), TO_W (wait counter width).
// Configuration macro: ALU_MULDIV_EN (MUL/DIV support with the T6 step).
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer
  import alu_ctrl_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        z_in,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        lo_in,
  output logic        hi_in,
  output logic        r_out_en,
  output logic        r_in_en,
  output logic [3:0]  r_sel,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        fault
);

  state_t          state, state_nx;
  logic [TO_W-1:0] wait_cnt;
  logic            fault_q;
  logic [31:IR_LO] ir_q;
  logic [31:IR_LO] ir_cur;
  op_class_t       op_class;
  ctrl_t           ctrl;
  logic            wait_expire;
  logic            unused_ir_bits;

  assign unused_ir_bits = ^ir[IR_LO-1:0];

  // In T3 the IR is taken straight from the input; later steps use the copy
  // captured at the end of T3, so the datapath may change ir afterwards.
  assign ir_cur = (state == S_T3) ? ir[31:IR_LO] : ir_q;

  alu_ctrl_sequencer_decode u_decode (
    .op       (ir_cur[OP_HI:OP_LO]),
    .op_class (op_class)
  );

  // Last permitted wait cycle with memory still not ready.
  assign wait_expire = (state == S_T1) && !mem_rdy &&
                       (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    if (clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      ir_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == S_T3) ir_q <= ir[31:IR_LO];
      if (state == S_T1 && !mem_rdy) wait_cnt <= wait_cnt + TO_W'(1);
      else                           wait_cnt <= '0;
      if (wait_expire) fault_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    ctrl     = '0;
    case (state)
      S_IDLE: if (run && !fault_q) state_nx = S_T0;

      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_nx    = S_T1;
      end

      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        if (mem_rdy) begin
          ctrl.pc_in = 1'b1;  // PC updated once, on the cycle T1 completes
          state_nx   = S_T2;
        end else if (wait_expire) begin
          state_nx = S_IDLE;
        end
      end

      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        state_nx     = S_T3;
      end

      S_T3: begin
        state_nx = S_T4;
        case (op_class)
          CLS_BINARY: begin
            ctrl.r_out_en = 1'b1;
            ctrl.r_sel    = ir_cur[RB_HI:RB_LO];
            ctrl.y_in     = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.r_out_en = 1'b1;
            ctrl.r_sel    = ir_cur[RB_HI:RB_LO];
            ctrl.alu_op   = ir_cur[OP_HI:OP_LO];
            ctrl.z_in     = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl.r_out_en = 1'b1;
            ctrl.r_sel    = ir_cur[RA_HI:RA_LO];
            ctrl.y_in     = 1'b1;
          end
          default: begin
            ctrl.illegal = 1'b1;
            state_nx     = S_IDLE;
          end
        endcase
      end

      S_T4: begin
        if (op_class == CLS_UNARY) begin
          ctrl.zlow_out = 1'b1;
          ctrl.r_in_en  = 1'b1;
          ctrl.r_sel    = ir_cur[RA_HI:RA_LO];
          ctrl.done     = 1'b1;
          state_nx      = run ? S_T0 : S_IDLE;
        end else begin
          // MUL/DIV feed Rb as the second operand; binary ops feed Rc.
          ctrl.r_out_en = 1'b1;
          ctrl.r_sel    = (op_class == CLS_MULDIV) ? ir_cur[RB_HI:RB_LO]
                                                   : ir_cur[RC_HI:RC_LO];
          ctrl.alu_op   = ir_cur[OP_HI:OP_LO];
          ctrl.z_in     = 1'b1;
          state_nx      = S_T5;
        end
      end

      S_T5: begin
`ifdef ALU_MULDIV_EN
        if (op_class == CLS_MULDIV) begin
          ctrl.zlow_out = 1'b1;
          ctrl.lo_in    = 1'b1;
          state_nx      = S_T6;
        end else
`endif
        begin
          ctrl.zlow_out = 1'b1;
          ctrl.r_in_en  = 1'b1;
          ctrl.r_sel    = ir_cur[RA_HI:RA_LO];
          ctrl.done     = 1'b1;
          state_nx      = run ? S_T0 : S_IDLE;
        end
      end

`ifdef ALU_MULDIV_EN
      S_T6: begin
        ctrl.zhigh_out = 1'b1;
        ctrl.hi_in     = 1'b1;
        ctrl.done      = 1'b1;
        state_nx       = run ? S_T0 : S_IDLE;
      end
`endif

      default: state_nx = S_IDLE;
    endcase

    // A clear silences the datapath immediately rather than one step late.
    if (clr) ctrl = '0;
  end

  assign pc_out    = ctrl.pc_out;
  assign mar_in    = ctrl.mar_in;
  assign inc_pc    = ctrl.inc_pc;
  assign z_in      = ctrl.z_in;
  assign pc_in     = ctrl.pc_in;
  assign read      = ctrl.read;
  assign mdr_in    = ctrl.mdr_in;
  assign mdr_out   = ctrl.mdr_out;
  assign ir_in     = ctrl.ir_in;
  assign y_in      = ctrl.y_in;
  assign zlow_out  = ctrl.zlow_out;
  assign zhigh_out = ctrl.zhigh_out;
  assign lo_in     = ctrl.lo_in;
  assign hi_in     = ctrl.hi_in;
  assign r_out_en  = ctrl.r_out_en;
  assign r_in_en   = ctrl.r_in_en;
  assign r_sel     = ctrl.r_sel;
  assign alu_op    = ctrl.alu_op;
  assign done      = ctrl.done;
  assign illegal   = ctrl.illegal;
  assign busy      = (state != S_IDLE);
  assign fault     = fault_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_sequencer
// Self-checking bench for alu_ctrl_sequencer. Every cycle the full output
// bundle is compared with the step the instruction-level model expects.
// Honours ALU_MULDIV_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_sequencer;

  localparam int MEM_TO = 15;

  logic        clk;
  logic        clr;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
  logic zlow_out, zhigh_out, lo_in, hi_in, r_out_en, r_in_en;
  logic [3:0] r_sel;
  logic [4:0] alu_op;
  logic busy, done, illegal, fault;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zlow_out, zhigh_out, lo_in, hi_in, r_out_en, r_in_en;
    logic done, illegal, busy, fault;
    logic [3:0] r_sel;
    logic [4:0] alu_op;
  } obs_t;

  obs_t obs;
  assign obs = {pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                zlow_out, zhigh_out, lo_in, hi_in, r_out_en, r_in_en,
                done, illegal, busy, fault, r_sel, alu_op};

  alu_ctrl_sequencer #(.MEM_TIMEOUT(MEM_TO), .TO_W(8)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .zlow_out(zlow_out), .zhigh_out(zhigh_out), .lo_in(lo_in), .hi_in(hi_in),
    .r_out_en(r_out_en), .r_in_en(r_in_en), .r_sel(r_sel), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int step_idx = 0;
  int clr_at   = -1;
  bit aborted  = 0;
  bit fault_m  = 0;
  bit next_t0  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Instruction class from the opcode table: 1 binary, 2 unary, 3 mul/div, 0 illegal.
  function automatic int op_kind(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return 1;
    if (op == 5'd17 || op == 5'd18) return 2;
`ifdef ALU_MULDIV_EN
    if (op == 5'd15 || op == 5'd16) return 3;
`endif
    return 0;
  endfunction

  function automatic obs_t busy_vec();
    obs_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // One clock: compare at the falling edge, then advance past the rising edge.
  // When clr_at names this step, clr is applied instead and only the strobes
  // are required to be silent.
  task automatic tick(input string tag, input obs_t e);
    obs_t o;
    if (step_idx == clr_at) begin
      clr = 1'b1;
      @(negedge clk);
      o = obs;
      o.busy  = 1'b0;
      o.fault = 1'b0;
      check({tag, "_clr"}, 32'(o), 32'(0));
      @(posedge clk); #1;
      clr     = 1'b0;
      aborted = 1'b1;
      fault_m = 1'b0;
      next_t0 = 1'b0;
    end else begin
      @(negedge clk);
      check(tag, 32'(obs), 32'(e));
      @(posedge clk); #1;
    end
    step_idx++;
  endtask

  task automatic idle_check(input string tag, input bit run_v);
    obs_t e = '0;
    run     = run_v;
    mem_rdy = 1'($urandom);
    e.fault = fault_m;
    tick(tag, e);
  endtask

  // Runs one instruction starting in T0: fetch with `waits` not-ready cycles,
  // then the execute steps for the opcode class.
  task automatic do_instr(input logic [31:0] ir_v, input int waits,
                          input bit run_mid, input bit run_next);
    obs_t e;
    obs_t ex[$];
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int kind;
    op = ir_v[31:27]; ra = ir_v[26:23]; rb = ir_v[22:19]; rc = ir_v[18:15];
    kind     = op_kind(op);
    step_idx = 0;
    aborted  = 1'b0;
    next_t0  = 1'b0;

    run = run_mid; mem_rdy = 1'($urandom); ir = $urandom;
    e = busy_vec(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    tick("T0", e);
    if (aborted) return;

    for (int w = 0; w <= waits; w++) begin
      e = busy_vec(); e.zlow_out = 1; e.read = 1; e.mdr_in = 1;
      if (w < waits) begin
        mem_rdy = 1'b0;
        tick("T1_wait", e);
        if (aborted) return;
        if (w + 1 == MEM_TO) begin
          fault_m = 1'b1;
          return;
        end
      end else begin
        mem_rdy = 1'b1;
        e.pc_in = 1;
        tick("T1_exit", e);
        if (aborted) return;
      end
    end

    mem_rdy = 1'($urandom);
    e = busy_vec(); e.mdr_out = 1; e.ir_in = 1;
    tick("T2", e);
    if (aborted) return;

    case (kind)
      1: begin
        e = busy_vec(); e.r_out_en = 1; e.r_sel = rb; e.y_in = 1; ex.push_back(e);
        e = busy_vec(); e.r_out_en = 1; e.r_sel = rc; e.alu_op = op; e.z_in = 1; ex.push_back(e);
        e = busy_vec(); e.zlow_out = 1; e.r_in_en = 1; e.r_sel = ra; e.done = 1; ex.push_back(e);
      end
      2: begin
        e = busy_vec(); e.r_out_en = 1; e.r_sel = rb; e.alu_op = op; e.z_in = 1; ex.push_back(e);
        e = busy_vec(); e.zlow_out = 1; e.r_in_en = 1; e.r_sel = ra; e.done = 1; ex.push_back(e);
      end
      3: begin
        e = busy_vec(); e.r_out_en = 1; e.r_sel = ra; e.y_in = 1; ex.push_back(e);
        e = busy_vec(); e.r_out_en = 1; e.r_sel = rb; e.alu_op = op; e.z_in = 1; ex.push_back(e);
        e = busy_vec(); e.zlow_out = 1; e.lo_in = 1; ex.push_back(e);
        e = busy_vec(); e.zhigh_out = 1; e.hi_in = 1; e.done = 1; ex.push_back(e);
      end
      default: begin
        e = busy_vec(); e.illegal = 1; ex.push_back(e);
      end
    endcase

    foreach (ex[i]) begin
      ir      = (i == 0) ? ir_v : $urandom;  // IR only valid in T3
      mem_rdy = 1'($urandom);
      if (i == ex.size() - 1 && kind != 0) run = run_next;
      tick($sformatf("T%0d_op%0d", i + 3, op), ex[i]);
      if (aborted) return;
    end
    next_t0 = (kind != 0) && run_next;
  endtask

  task automatic fault_recover();
    obs_t z = '0;
    repeat (3) idle_check("fault_hold", 1'b1);
    clr_at = step_idx;
    tick("fault_clr", z);
    clr_at = -1;
    idle_check("after_fault_clr", 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, waits, pick;
    logic [4:0] op;
    logic [31:0] ir_v;
    int ops[$] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};

    clr = 1'b1; run = 1'b0; mem_rdy = 1'b0; ir = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", 32'(obs), 32'(0));
    @(posedge clk); #1;
    clr = 1'b0;

    // AND R1,R2,R3
    idle_check("and_idle", 1'b1);
    do_instr(32'h28918000, 0, 1'b1, 1'b0);
    idle_check("and_after", 1'b0);

    // ROL with four not-ready cycles in T1, run dropped mid-instruction
    idle_check("rol_idle", 1'b1);
    do_instr(32'h59918000, 4, 1'b0, 1'b0);
    idle_check("rol_after", 1'b0);

    // Unsupported opcode 11111
    idle_check("ill_idle", 1'b1);
    do_instr({5'b11111, 27'h1234567}, 0, 1'b1, 1'b1);
    idle_check("ill_after", 1'b0);

    // MUL: legal only with the multiply/divide option
    idle_check("mul_idle", 1'b1);
    do_instr(32'h79100000, 0, 1'b1, 1'b0);
    idle_check("mul_after", 1'b0);

    // Back-to-back: SUB then NEG with run held
    idle_check("b2b_idle", 1'b1);
    do_instr(32'h20918000, 1, 1'b1, 1'b1);
    do_instr(32'h88880000, 0, 1'b1, 1'b0);
    idle_check("b2b_after", 1'b0);

    // Longest legal wait, then timeout
    idle_check("w14_idle", 1'b1);
    do_instr(32'h18918000, MEM_TO - 1, 1'b1, 1'b0);
    idle_check("w14_after", 1'b0);
    idle_check("to_idle", 1'b1);
    do_instr(32'h18918000, MEM_TO + 5, 1'b1, 1'b0);
    fault_recover();

    // clr during T4, then restart
    idle_check("clr_idle", 1'b1);
    clr_at = 4;
    do_instr(32'h28918000, 0, 1'b1, 1'b1);
    clr_at = -1;
    idle_check("clr_after", 1'b1);
    do_instr(32'h28918000, 0, 1'b1, 1'b0);
    idle_check("clr_restart_after", 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if (!next_t0) idle_check("rnd_idle", 1'b1);
      pick = $urandom_range(0, 3);
      if (pick == 0) op = 5'($urandom);
      else           op = 5'(ops[$urandom_range(0, ops.size() - 1)]);
      ir_v = {op, 27'($urandom)};
      r = $urandom_range(0, 15);
      if      (r < 10) waits = $urandom_range(0, 3);
      else if (r < 12) waits = MEM_TO - 1;
      else if (r < 13) waits = MEM_TO;
      else             waits = $urandom_range(4, 10);
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      do_instr(ir_v, waits, 1'($urandom), 1'($urandom));
      clr_at = -1;
      if (fault_m) fault_recover();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
